// File: rtl/pp_seq_accumulator_pkg.sv
// Shared constants and types for the sequential carry-save multiplier.
// Holds the operand width, the FSM state encoding and the row-placement helper.
package pp_seq_accumulator_pkg;

  localparam int WIDTH = 32;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE
  } state_e;

  // Zero-extend an AND-row to product width and move it to the weight of B[k].
  function automatic logic [PW-1:0] place_row(input logic [WIDTH-1:0] pp,
                                              input logic [CNT_W-1:0] k);
    logic [PW-1:0] ext;
    ext = {{WIDTH{1'b0}}, pp};
    return ext << k;
  endfunction

endpackage

// File: rtl/pp_seq_accumulator_if.sv
// Start/busy/done handshake plus operand and product buses between the
// datapath controller (master) and the accumulator (slave).
interface pp_seq_accumulator_if
  import pp_seq_accumulator_pkg::*;
();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [PW-1:0]    P;

  modport master (
    output start,
    output A,
    output B,
    input  busy,
    input  done,
    input  P
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output busy,
    output done,
    output P
  );

endinterface

// File: rtl/pp_seq_accumulator_csa.sv
// Generic 3:2 carry-save compressor; the majority output is left unshifted so the
// caller decides how carries are weighted.
module csa_3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] maj_o
);

  assign sum_o = x_i ^ y_i ^ z_i;
  assign maj_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);

endmodule

// File: rtl/pp_seq_accumulator_pprow.sv
// AND-row partial-product generator: one multiplicand row gated by one multiplier bit.
module pp_and_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic         b_bit_i,
  output logic [W-1:0] row_o
);

  assign row_o = a_i & {W{b_bit_i}};

endmodule

// File: rtl/pp_seq_accumulator.sv
// Iterative multiplier: one partial-product row per clock folded into sum/carry
// registers by a 3:2 compressor, then a single carry-propagate resolve cycle.
module pp_seq_accumulator
  import pp_seq_accumulator_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  pp_seq_accumulator_if.slave         bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      sum_q, sum_d;
  logic [PW-1:0]      carry_q, carry_d;
  logic [PW-1:0]      p_q, p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   pp_row;
  logic [PW-1:0]      row;
  logic [PW-1:0]      csa_sum;
  logic [PW-1:0]      csa_maj;

  pp_and_row #(
    .W (WIDTH)
  ) u_pp_row (
    .a_i     (a_q),
    .b_bit_i (b_q[k_q]),
    .row_o   (pp_row)
  );

  assign row = place_row(pp_row, k_q);

  csa_3to2 #(
    .W (PW)
  ) u_csa (
    .x_i   (sum_q),
    .y_i   (carry_q),
    .z_i   (row),
    .sum_o (csa_sum),
    .maj_o (csa_maj)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sum_d   = '0;
          carry_d = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end

      // Carry shift drops the top majority bit; the product never reaches it.
      ACCUM: begin
        sum_d   = csa_sum;
        carry_d = {csa_maj[PW-2:0], 1'b0};
        k_d     = k_q + CNT_W'(1);
        if (k_q == CNT_W'(WIDTH - 1)) begin
          state_d = RESOLVE;
        end
      end

      RESOLVE: begin
        p_d     = sum_q + carry_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.P    = p_q;

endmodule

// File: tb/tb_pp_seq_accumulator.sv
// Bench for pp_seq_accumulator: directed product table, handshake corner cases
// and randomized products compared with a plain 64-bit multiply.
module tb_pp_seq_accumulator;
  import pp_seq_accumulator_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleCnt   = 0;

  pp_seq_accumulator_if bus ();

  pp_seq_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Called at a negedge while idle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges from the accepting edge until done; optionally pulses a
  // junk start while the operation is busy.
  task automatic waitDone(input int junkAt, output int lat, output int busyCyc);
    lat     = 0;
    busyCyc = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      busyCyc += int'(bus.busy);
      if (lat == junkAt) begin
        bus.start = 1'b1;
        bus.A     = $urandom;
        bus.B     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    vec_t        vecs[8];
    int          lat;
    int          busyCyc;
    int          lastDone;
    int          gap;
    int          junk;
    int          doneSeen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] refP;

    vecs[0] = '{32'h3,        32'h5,        64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'h0,        32'h1234_5678, 64'h0};
    vecs[4] = '{32'h1234_5678, 32'h0,        64'h0};
    vecs[5] = '{32'h1,        32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{32'hFFFF_FFFF, 32'h2,        64'h0000_0001_FFFF_FFFE};
    vecs[7] = '{32'h6,        32'h7,        64'd42};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    #12;
    checkOutput("reset_P", bus.P, 64'h0);
    checkOutput("reset_busy", 64'(bus.busy), 64'h0);
    checkOutput("reset_done", 64'(bus.done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_P", bus.P, 64'h0);
      checkOutput("idle_busy_done", 64'({bus.busy, bus.done}), 64'h0);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      waitDone(-1, lat, busyCyc);
      checkOutput($sformatf("vec%0d_P", i), bus.P, vecs[i].p);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(busyCyc), 64'd33);
      checkOutput($sformatf("vec%0d_busy_at_done", i), 64'(bus.busy), 64'h0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'h0);
    end

    applyStimulus(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'd2;
    bus.B     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(-1, lat, busyCyc);
    checkOutput("busy_start_P", bus.P, 64'd63);
    checkOutput("busy_start_latency", 64'(lat + 10), 64'd33);

    applyStimulus(32'd2, 32'd2);
    waitDone(-1, lat, busyCyc);
    checkOutput("chain_P", bus.P, 64'd4);
    checkOutput("chain_latency", 64'(lat), 64'd33);

    applyStimulus(32'hFFFF, 32'hFFFF);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_P", bus.P, 64'h0);
    checkOutput("midreset_busy", 64'(bus.busy), 64'h0);
    checkOutput("midreset_done", 64'(bus.done), 64'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      doneSeen += int'(bus.done);
    end
    checkOutput("midreset_no_done", 64'(doneSeen), 64'h0);
    checkOutput("midreset_P_held", bus.P, 64'h0);
    applyStimulus(32'd6, 32'd7);
    waitDone(-1, lat, busyCyc);
    checkOutput("after_reset_P", bus.P, 64'd42);
    checkOutput("after_reset_latency", 64'(lat), 64'd33);

    lastDone = cycleCnt;
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      ra   = $urandom;
      rb   = $urandom;
      junk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1;
      refP = 64'(ra) * 64'(rb);
      applyStimulus(ra, rb);
      waitDone(junk, lat, busyCyc);
      checkOutput($sformatf("rand%0d_P", n), bus.P, refP);
      checkOutput($sformatf("rand%0d_latency", n), 64'(lat), 64'd33);
      checkOutput($sformatf("rand%0d_done_spacing", n),
                  64'(cycleCnt - lastDone >= 33), 64'h1);
      lastDone = cycleCnt;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
